// File: rtl/pick_voq_core.sv
// VOQ selector for one crossbar ingress: picks the egress to dequeue from,
// round-robin or priority, with zero-latency selection and registered config.
module pick_voq_core (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] start_voq_num,
   input  logic [3:0] voq_empty,
   input  logic [3:0] voq_picked,
   input  logic       policy,
   input  logic [7:0] prio,
   output logic       no_available_voq,
   output logic [1:0] voq_to_pick
);

   logic       r_policy_q;
   logic [7:0] r_prio_q;

   logic [3:0] w_avail;
   logic       w_found;
   logic [1:0] w_pick;
   logic [1:0] w_best;
   logic [1:0] w_idx;
   logic [1:0] w_pri;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_policy_q <= 1'b0;
         r_prio_q   <= 8'h00;
      end else begin
         r_policy_q <= policy;
         r_prio_q   <= prio;
      end
   end

   assign w_avail = ~voq_empty & ~voq_picked;

   // One scan in search order serves both policies: in RR every candidate
   // has priority 0, and the strict '>' keeps the earliest on ties.
   always_comb begin
      w_found = 1'b0;
      w_pick  = 2'b00;
      w_best  = 2'b00;
      w_idx   = 2'b00;
      w_pri   = 2'b00;
      for (int k = 0; k < 4; k++) begin
         w_idx = start_voq_num + 2'(k);
         w_pri = r_policy_q ? r_prio_q[{w_idx, 1'b0} +: 2] : 2'b00;
         if (w_avail[w_idx] && (!w_found || (w_pri > w_best))) begin
            w_found = 1'b1;
            w_pick  = w_idx;
            w_best  = w_pri;
         end
      end
   end

   assign no_available_voq = ~w_found;
   assign voq_to_pick      = w_found ? w_pick : 2'b00;

endmodule

// File: tb/tb_pick_voq_core.sv
// Directed bench for pick_voq_core: hand-computed expectations for RR,
// priority, tie-break, empty/picked corners and config/reset latency.
module tb_pick_voq_core;

   logic       clk;
   logic       reset;
   logic [1:0] start_voq_num;
   logic [3:0] voq_empty;
   logic [3:0] voq_picked;
   logic       policy;
   logic [7:0] prio;
   logic       no_available_voq;
   logic [1:0] voq_to_pick;

   int n_tests;
   int n_fail;

   pick_voq_core dut (
      .clk              (clk),
      .reset            (reset),
      .start_voq_num    (start_voq_num),
      .voq_empty        (voq_empty),
      .voq_picked       (voq_picked),
      .policy           (policy),
      .prio             (prio),
      .no_available_voq (no_available_voq),
      .voq_to_pick      (voq_to_pick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and land 1 time unit after it.
   task automatic step_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] s, input logic [3:0] e, input logic [3:0] p);
      start_voq_num = s;
      voq_empty     = e;
      voq_picked    = p;
      #1;
   endtask

   task automatic check(input string tag, input logic [1:0] exp_pick, input logic exp_none);
      n_tests++;
      assert (voq_to_pick === exp_pick) else begin
         n_fail++;
         $error("FAIL %s voq_to_pick observed=%0d expected=%0d", tag, voq_to_pick, exp_pick);
      end
      n_tests++;
      assert (no_available_voq === exp_none) else begin
         n_fail++;
         $error("FAIL %s no_available_voq observed=%0d expected=%0d", tag, no_available_voq, exp_none);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b1;
      policy  = 1'b1;
      prio    = 8'hC0;   // VOQ3 would win in priority mode
      drive(2'd0, 4'b0000, 4'b0000);
      step_clk();
      step_clk();
      // Reset forces RR even though priority config sits on the inputs
      check("reset_rr", 2'd0, 1'b0);

      reset  = 1'b0;
      policy = 1'b0;
      prio   = 8'h00;
      step_clk();

      drive(2'd3, 4'b1000, 4'b0000);
      check("rr_wrap", 2'd0, 1'b0);
      drive(2'd1, 4'b0000, 4'b0110);
      check("rr_skip_picked", 2'd3, 1'b0);
      drive(2'd2, 4'b0101, 4'b1010);
      check("none_available", 2'd0, 1'b1);
      drive(2'd1, 4'b0000, 4'b1111);
      check("all_picked", 2'd0, 1'b1);
      drive(2'd3, 4'b1111, 4'b0000);
      check("all_empty", 2'd0, 1'b1);
      drive(2'd2, 4'b0000, 4'b0000);
      check("rr_start2", 2'd2, 1'b0);

      // Priority: VOQ3=0 VOQ2=3 VOQ1=1 VOQ0=2
      policy = 1'b1;
      prio   = 8'b00_11_01_10;
      drive(2'd0, 4'b0000, 4'b0000);
      check("prio_before_edge", 2'd0, 1'b0);
      step_clk();
      check("prio_basic", 2'd2, 1'b0);
      drive(2'd0, 4'b0000, 4'b0100);
      check("prio_skip_picked", 2'd0, 1'b0);
      drive(2'd3, 4'b0000, 4'b0101);
      check("prio_low_pair", 2'd1, 1'b0);
      drive(2'd1, 4'b0110, 4'b1001);
      check("prio_none", 2'd0, 1'b1);

      // Tie: new prio not yet loaded, old prio still rules
      prio = 8'hFF;
      drive(2'd2, 4'b0100, 4'b0000);
      check("tie_before_edge", 2'd0, 1'b0);
      step_clk();
      check("prio_tie_start2", 2'd3, 1'b0);
      drive(2'd0, 4'b0100, 4'b0000);
      check("prio_tie_start0", 2'd0, 1'b0);

      // Priority mode with all-zero priorities behaves as RR
      prio = 8'h00;
      step_clk();
      drive(2'd1, 4'b0010, 4'b0000);
      check("prio_zero_is_rr", 2'd2, 1'b0);

      // Reset/config latency
      prio = 8'b00_11_01_10;
      step_clk();
      drive(2'd1, 4'b0000, 4'b0000);
      check("prio_pre_reset", 2'd2, 1'b0);
      reset = 1'b1;
      step_clk();
      check("reset_midround_rr", 2'd1, 1'b0);
      reset  = 1'b0;
      policy = 1'b0;
      step_clk();
      check("rr_after_reset", 2'd1, 1'b0);
      // Simultaneous policy and data change: data immediate, policy next edge
      policy = 1'b1;
      drive(2'd3, 4'b0000, 4'b0000);
      check("policy_no_edge", 2'd3, 1'b0);
      step_clk();
      check("policy_after_edge", 2'd2, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
